periph_bus_arbiter: RTL and testbench

Two-master arbiter and transaction sequencer for the memory-mapped peripheral bus (GPIO and sibling slaves using the access/we/addr/wd/mask_type → ack/err/rd protocol). Master 0 is the core's memory stage; master 1 is the debug/DMA port. The block grants one master at a time and issues a single-cycle access strobe to the slave. It waits for the slave's ack with a timeout, then returns a registered one-cycle response to the granted master.

---
 rtl/periph_bus_arbiter_if.sv | 56 +++++
 rtl/periph_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_if.sv
// ============================================================================
// periph_bus_arbiter_if : two-master / one-slave peripheral bus bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface periph_bus_arbiter_if;
  // master 0 (core memory stage)
  logic        i_m0_req;
  logic        i_m0_we;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wd;
  logic [1:0]  i_m0_mask_type;
  logic        o_m0_ack;
  logic        o_m0_err;
  logic [31:0] o_m0_rd;
  // master 1 (debug / DMA port)
  logic        i_m1_req;
  logic        i_m1_we;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wd;
  logic [1:0]  i_m1_mask_type;
  logic        o_m1_ack;
  logic        o_m1_err;
  logic [31:0] o_m1_rd;
  // downstream peripheral slave
  logic        o_s_addr_access;
  logic        o_s_we;
  logic [31:0] o_s_addr;
  logic [31:0] o_s_wd;
  logic [1:0]  o_s_mask_type;
  logic        i_s_ack;
  logic        i_s_err;
  logic [31:0] i_s_rd;

  // slave: the arbiter's view; master: the surrounding masters and peripheral
  modport slave (
    input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wd, i_m0_mask_type,
    input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wd, i_m1_mask_type,
    input  i_s_ack, i_s_err, i_s_rd,
    output o_m0_ack, o_m0_err, o_m0_rd,
    output o_m1_ack, o_m1_err, o_m1_rd,
    output o_s_addr_access, o_s_we, o_s_addr, o_s_wd, o_s_mask_type
  );

  modport master (
    output i_m0_req, i_m0_we, i_m0_addr, i_m0_wd, i_m0_mask_type,
    output i_m1_req, i_m1_we, i_m1_addr, i_m1_wd, i_m1_mask_type,
    output i_s_ack, i_s_err, i_s_rd,
    input  o_m0_ack, o_m0_err, o_m0_rd,
    input  o_m1_ack, o_m1_err, o_m1_rd,
    input  o_s_addr_access, o_s_we, o_s_addr, o_s_wd, o_s_mask_type
  );
endinterface

`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
// ============================================================================
// periph_bus_arbiter : round-robin two-master arbiter and transaction sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_bus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  periph_bus_arbiter_if.slave  bus
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          grant, grant_nx;
  logic          last_served;
  logic [CW-1:0] cnt, cnt_nx;
  logic          resp_err, resp_err_nx;
  logic [31:0]   resp_rd, resp_rd_nx;
  logic          s_we;
  logic [31:0]   s_addr, s_wd;
  logic [1:0]    s_mask;
  logic          latch;
  logic          pick;
  logic [1:0]    pick_mask;

  always_comb begin
    pick      = (bus.i_m0_req && bus.i_m1_req) ? ~last_served : bus.i_m1_req;
    pick_mask = pick ? bus.i_m1_mask_type : bus.i_m0_mask_type;

    state_nx    = state;
    grant_nx    = grant;
    cnt_nx      = cnt;
    resp_err_nx = resp_err;
    resp_rd_nx  = resp_rd;
    latch       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_m0_req || bus.i_m1_req) begin
          latch    = 1'b1;
          grant_nx = pick;
          // Invalid mask is answered locally; the slave never sees it.
          if (pick_mask == 2'b11) begin
            state_nx    = RESP;
            resp_err_nx = 1'b1;
            resp_rd_nx  = 32'd0;
          end else begin
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (bus.i_s_ack) begin
          resp_err_nx = bus.i_s_err;
          resp_rd_nx  = bus.i_s_rd;
          state_nx    = RESP;
        end else if (cnt == C_TIMEOUT) begin
          resp_err_nx = 1'b1;
          resp_rd_nx  = 32'd0;
          state_nx    = RESP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // last_served resets to 1 so master 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      grant       <= 1'b0;
      last_served <= 1'b1;
      cnt         <= '0;
      resp_err    <= 1'b0;
      resp_rd     <= 32'd0;
      s_we        <= 1'b0;
      s_addr      <= 32'd0;
      s_wd        <= 32'd0;
      s_mask      <= 2'b00;
    end else begin
      grant    <= grant_nx;
      cnt      <= cnt_nx;
      resp_err <= resp_err_nx;
      resp_rd  <= resp_rd_nx;
      if (state != RESP && state_nx == RESP) begin
        last_served <= grant_nx;
      end
      if (latch) begin
        s_we   <= pick ? bus.i_m1_we        : bus.i_m0_we;
        s_addr <= pick ? bus.i_m1_addr      : bus.i_m0_addr;
        s_wd   <= pick ? bus.i_m1_wd        : bus.i_m0_wd;
        s_mask <= pick_mask;
      end
    end
  end

  assign bus.o_s_addr_access = (state == ISSUE);
  assign bus.o_s_we          = s_we;
  assign bus.o_s_addr        = s_addr;
  assign bus.o_s_wd          = s_wd;
  assign bus.o_s_mask_type   = s_mask;

  assign bus.o_m0_ack = (state == RESP) && !grant;
  assign bus.o_m1_ack = (state == RESP) &&  grant;
  assign bus.o_m0_err = bus.o_m0_ack && resp_err;
  assign bus.o_m1_err = bus.o_m1_ack && resp_err;
  assign bus.o_m0_rd  = bus.o_m0_ack ? resp_rd : 32'd0;
  assign bus.o_m1_rd  = bus.o_m1_ack ? resp_rd : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
// ============================================================================
// tb_periph_bus_arbiter : directed self-checking bench for periph_bus_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_arbiter;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  periph_bus_arbiter_if bus ();

  periph_bus_arbiter #(.TIMEOUT(15)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
  endtask

  // Starts in IDLE with requests already driven; ends back in IDLE.
  task automatic serve(input int m, input logic [31:0] addr, input logic [31:0] rd,
                       input logic err, input logic drop);
    tick();
    check("strobe", bus.o_s_addr_access, 1);
    check("s_addr", bus.o_s_addr, addr);
    tick();
    bus.i_s_ack = 1'b1;
    bus.i_s_rd  = rd;
    bus.i_s_err = err;
    tick();
    bus.i_s_ack = 1'b0;
    bus.i_s_rd  = 32'd0;
    bus.i_s_err = 1'b0;
    check("ack_granted", (m == 0) ? bus.o_m0_ack : bus.o_m1_ack, 1);
    check("ack_other",   (m == 0) ? bus.o_m1_ack : bus.o_m0_ack, 0);
    check("err",         (m == 0) ? bus.o_m0_err : bus.o_m1_err, err);
    check("rd",          (m == 0) ? bus.o_m0_rd  : bus.o_m1_rd,  rd);
    if (drop) begin
      if (m == 0) bus.i_m0_req = 1'b0;
      else        bus.i_m1_req = 1'b0;
    end
    tick();
    check("ack_done", bus.o_m0_ack | bus.o_m1_ack, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_m0_req = 0; bus.i_m0_we = 0; bus.i_m0_addr = 0; bus.i_m0_wd = 0; bus.i_m0_mask_type = 0;
    bus.i_m1_req = 0; bus.i_m1_we = 0; bus.i_m1_addr = 0; bus.i_m1_wd = 0; bus.i_m1_mask_type = 0;
    bus.i_s_ack = 0;  bus.i_s_err = 0; bus.i_s_rd = 0;

    repeat (2) tick();
    check("rst_access", bus.o_s_addr_access, 0);
    check("rst_ack",    {bus.o_m0_ack, bus.o_m1_ack, bus.o_m0_err, bus.o_m1_err}, 0);
    check("rst_s_addr", bus.o_s_addr, 0);
    check("rst_rd",     bus.o_m0_rd | bus.o_m1_rd, 0);
    i_rst = 1'b1;
    tick();

    // m0 word write, 1-cycle slave
    bus.i_m0_req = 1; bus.i_m0_we = 1; bus.i_m0_addr = 32'hFFFF_FFFC;
    bus.i_m0_wd = 32'hA5A5_0F0F; bus.i_m0_mask_type = 2'b10;
    tick();
    check("wr_strobe", bus.o_s_addr_access, 1);
    check("wr_we",     bus.o_s_we, 1);
    check("wr_addr",   bus.o_s_addr, 32'hFFFF_FFFC);
    check("wr_wd",     bus.o_s_wd, 32'hA5A5_0F0F);
    check("wr_mask",   bus.o_s_mask_type, 2'b10);
    tick();
    check("wr_strobe_once", bus.o_s_addr_access, 0);
    bus.i_s_ack = 1;
    tick();
    bus.i_s_ack = 0;
    check("wr_ack",    bus.o_m0_ack, 1);
    check("wr_err",    bus.o_m0_err, 0);
    check("wr_m1",     {bus.o_m1_ack, bus.o_m1_err} | bus.o_m1_rd, 0);
    check("wr_stable", bus.o_s_addr, 32'hFFFF_FFFC);
    bus.i_m0_req = 0;
    tick();
    check("wr_idle", bus.o_m0_ack, 0);

    // simultaneous reads after reset, then continuous alternation
    do_reset();
    bus.i_m0_we = 0; bus.i_m0_addr = 32'h100; bus.i_m0_mask_type = 2'b10;
    bus.i_m1_we = 0; bus.i_m1_addr = 32'h200; bus.i_m1_mask_type = 2'b10;
    bus.i_m1_wd = 32'h1234_5678;
    bus.i_m0_req = 1; bus.i_m1_req = 1;
    serve(0, 32'h100, 32'h11, 1'b0, 1'b1);
    serve(1, 32'h200, 32'h22, 1'b0, 1'b1);
    bus.i_m0_req = 1; bus.i_m1_req = 1;
    serve(0, 32'h100, 32'h33, 1'b0, 1'b0);
    serve(1, 32'h200, 32'h44, 1'b0, 1'b0);
    serve(0, 32'h100, 32'h55, 1'b0, 1'b0);
    serve(1, 32'h200, 32'h66, 1'b0, 1'b1);
    bus.i_m0_req = 0;

    // m1 timeout: ack must appear at cycle 18 exactly
    bus.i_m1_addr = 32'h300; bus.i_m1_mask_type = 2'b01; bus.i_m1_req = 1;
    tick();
    check("to_strobe", bus.o_s_addr_access, 1);
    repeat (16) tick();
    check("to_early", bus.o_m1_ack, 0);
    tick();
    check("to_ack", bus.o_m1_ack, 1);
    check("to_err", bus.o_m1_err, 1);
    check("to_rd",  bus.o_m1_rd, 0);
    bus.i_m1_req = 0;
    tick();
    bus.i_s_ack = 1; bus.i_s_rd = 32'h77;
    tick();
    check("stray_ack", bus.o_m0_ack | bus.o_m1_ack | bus.o_s_addr_access, 0);
    bus.i_s_ack = 0; bus.i_s_rd = 0;
    tick();
    check("stray_ack2", bus.o_m0_ack | bus.o_m1_ack, 0);

    // m0 invalid mask: local error, no strobe
    bus.i_m0_mask_type = 2'b11; bus.i_m0_req = 1;
    tick();
    check("inv_strobe", bus.o_s_addr_access, 0);
    check("inv_ack",    bus.o_m0_ack, 1);
    check("inv_err",    bus.o_m0_err, 1);
    check("inv_rd",     bus.o_m0_rd, 0);
    bus.i_m0_req = 0; bus.i_m0_mask_type = 2'b10;
    tick();
    check("inv_idle", bus.o_m0_ack | bus.o_s_addr_access, 0);

    // reset while m1 is in WAIT; last_served was 0 before the reset
    bus.i_m1_addr = 32'h200; bus.i_m1_mask_type = 2'b10; bus.i_m1_req = 1;
    tick();
    check("ab_strobe", bus.o_s_addr_access, 1);
    tick();
    #2;
    i_rst = 1'b0;
    #1;
    check("ab_access", bus.o_s_addr_access, 0);
    check("ab_s_addr", bus.o_s_addr, 0);
    check("ab_s_wd",   bus.o_s_wd, 0);
    check("ab_s_ctl",  {bus.o_s_we, bus.o_s_mask_type}, 0);
    check("ab_ack",    bus.o_m1_ack | bus.o_m0_ack, 0);
    bus.i_s_ack = 1; bus.i_s_rd = 32'hBAD;
    bus.i_m0_req = 1;
    tick();
    check("ab_hold", bus.o_m1_ack | bus.o_m0_ack, 0);
    i_rst = 1'b1;
    bus.i_s_ack = 0; bus.i_s_rd = 0;
    serve(0, 32'h100, 32'h99, 1'b0, 1'b1);
    serve(1, 32'h200, 32'hAA, 1'b0, 1'b1);

    // slave error on an m1 read
    bus.i_m1_req = 1;
    serve(1, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
